fetch_controller: RTL and testbench

//  Sequences instruction fetch for the ARM core: owns the fetch PC, issues word reads to the

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_controller.sv | 152 +++++++++++++++
 tb/tb_fetch_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch slice.
//   - fetch_state_e : fetch sequencer states (IDLE, RUN, DRAIN)
//   - PC_STEP       : byte increment between sequential fetches
//   - fetch_entry_t : one prefetch-queue entry (instruction word + its PC)
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Small prefetch FIFO of fetch_entry_t. Push and pop may happen in the same
//   cycle (count unchanged). Flush empties the queue and wins over push/pop.
//   The head is read straight from the storage registers, so a word pushed at
//   the end of cycle N is presented at the head during cycle N+1.
//
// Ports
//   clk, reset  clock and asynchronous active-high reset
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         drop the head entry (caller guarantees the queue is not empty)
//   flush       discard all entries
//   head        entry at the head of the queue
//   valid       queue holds at least one entry
//   count       number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  // NOTE: the storage is reset as well; it is tiny, and it makes the head
  // (and therefore the instr/instr_pc outputs) read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//   Owns the fetch PC, issues word reads to a synchronous instruction memory
//   (data returns the cycle after the request), buffers returned words in a
//   prefetch queue and presents them to decode over valid/ready. Redirects
//   flush the queue and restart fetch at the new PC.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset (word aligned)
//   QDEPTH    prefetch queue entries (power of 2, >= 2)
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   run             1 = fetch enabled, 0 = stop issuing new reads
//   imem_req        read strobe to instruction memory this cycle
//   imem_addr       byte address of the read (the fetch PC)
//   imem_rdata      read data, valid the cycle after imem_req
//   instr           instruction at queue head
//   instr_pc        byte address of instr
//   instr_valid     queue head valid
//   instr_ready     decode accepts the head (fire = valid & ready)
//   redirect_valid  redirect fetch to redirect_pc and flush the queue
//   redirect_pc     new PC, low two bits forced to zero
//   busy            sequencer not idle, or a read is in flight
// ----------------------------------------------------------------------------
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(QDEPTH) + 1;

  // One bit wider than the queue count so count + inflight cannot wrap.
  typedef logic [CW:0] occ_t;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   tag_pc_q;
  logic          inflight_q;
  logic          kill_q;

  logic          fire;
  logic          issue;
  logic          push;
  occ_t          occupancy;
  occ_t          limit;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;

  assign fire = instr_valid & instr_ready;

  // Issue only while the queue can take the word when it lands:
  // count + inflight - fire < QDEPTH, rearranged to avoid a subtraction.
  assign occupancy = occ_t'(q_count) + occ_t'(inflight_q);
  assign limit     = occ_t'(QDEPTH) + occ_t'(fire);

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          // A read issued last cycle lands now; DRAIN covers the cycle it is
          // handed to the queue before the sequencer reports idle.
          state_d = inflight_q ? DRAIN : IDLE;
        end else begin
          issue = !redirect_valid && (occupancy < limit);
        end
      end
      DRAIN: begin
        if (!inflight_q) state_d = run ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The returning word is dropped if a redirect arrives the same cycle (the
  // flush wins) or if it was marked stale by an earlier redirect.
  assign push       = inflight_q & ~kill_q & ~redirect_valid;
  assign push_entry = '{instr: imem_rdata, pc: tag_pc_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      // With a 1-cycle memory the only outstanding word returns in the
      // redirect cycle itself and is removed by the flush; kill marks any
      // response still outstanding past the redirect as stale.
      kill_q     <= redirect_valid & inflight_q;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & ~32'h3;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + PC_STEP;
      end
      if (issue) begin
        tag_pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (fire),
    .flush     (redirect_valid),
    .head      (q_head),
    .valid     (instr_valid),
    .count     (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign instr     = q_head.instr;
  assign instr_pc  = q_head.pc;
  assign busy      = (state_q != IDLE) | inflight_q;

endmodule

// File: tb/tb_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_fetch_controller
//   Self-checking bench for fetch_controller. A 1-cycle synchronous memory
//   model answers reads; a negedge monitor keeps an expected-PC model and a
//   scoreboard queue of words that must reach decode, in order. Directed
//   sequences exercise fill latency, back-pressure, redirect, run drop, PC
//   wrap and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  exp_t        exp_q[$];
  exp_t        pend;
  logic        pend_v;
  logic [31:0] exp_pc;

  fetch_controller #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_0001;
      32'h0000_0004: return 32'hE3A0_1002;
      32'h0000_0008: return 32'hE080_0001;
      default:       return a ^ 32'h5EED_0000;
    endcase
  endfunction

  // 1-cycle synchronous instruction memory
  always @(posedge clk or posedge reset) begin
    if (reset) imem_rdata <= '0;
    else if (imem_req) imem_rdata <= mem_word({imem_addr[31:2], 2'b00});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend_v = 1'b0;
      exp_pc = RESET_PC;
    end else begin
      if (instr_valid && instr_ready) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_pc", instr_pc, e.pc);
        end
      end
      if (redirect_valid) begin
        check("redirect_no_req", 32'(imem_req), 32'd0);
        exp_q.delete();
        pend_v = 1'b0;
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (pend_v) exp_q.push_back(pend);
        pend_v = imem_req;
        if (imem_req) begin
          check("req_addr", imem_addr, exp_pc);
          pend   = '{instr: mem_word(exp_pc), pc: exp_pc};
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Bounded wait for the next request; a timeout is a failed comparison.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  imem_addr,        RESET_PC);
    check("rst_instr", instr,            32'd0);
    check("rst_pc",    instr_pc,         32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);

    // 1: fill latency and sustained throughput
    step();
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    wait_req("t1_req0_seen");
    check("t1_addr0",  imem_addr,        32'h0);
    check("t1_valid0", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_addr1",  imem_addr,        32'h4);
    check("t1_req1",   32'(imem_req),    32'd1);
    check("t1_valid1", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_addr2",  imem_addr,        32'h8);
    check("t1_valid2", 32'(instr_valid), 32'd1);
    check("t1_instr2", instr,            32'hE3A0_0001);
    check("t1_pc2",    instr_pc,         32'h0);
    @(negedge clk);
    check("t1_instr3", instr,            32'hE3A0_1002);
    check("t1_pc3",    instr_pc,         32'h4);
    @(negedge clk);
    check("t1_valid4", 32'(instr_valid), 32'd1);
    check("t1_instr4", instr,            32'hE080_0001);
    check("t1_pc4",    instr_pc,         32'h8);

    // 2: back-pressure from cycle 2 fills exactly QDEPTH entries
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    wait_req("t2_req0_seen");
    step();
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_stall_req",   32'(imem_req),    32'd0);
      check("t2_stall_valid", 32'(instr_valid), 32'd1);
      check("t2_stall_instr", instr,            32'hE3A0_0001);
    end
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("t2_rel_instr0", instr, 32'hE3A0_0001);
    @(negedge clk);
    check("t2_rel_instr1", instr, 32'hE3A0_1002);
    @(negedge clk);
    check("t2_rel_instr2", instr, 32'hE080_0001);
    check("t2_rel_pc2",    instr_pc, 32'h8);

    // 3: redirect while a read is in flight
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    wait_req("t3_req0_seen");
    repeat (3) @(negedge clk);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    @(negedge clk);
    check("t3_redir_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_valid_after", 32'(instr_valid), 32'd0);
    check("t3_req_after",   32'(imem_req),    32'd1);
    check("t3_addr_after",  imem_addr,        32'h40);
    @(negedge clk);
    @(negedge clk);
    check("t3_first_valid", 32'(instr_valid), 32'd1);
    check("t3_first_pc",    instr_pc,         32'h40);
    check("t3_first_instr", instr,            32'h5EED_0040);

    // 4: run dropped with a read in flight
    step();
    run = 1'b0;
    @(negedge clk);
    check("t4_d0_req",  32'(imem_req), 32'd0);
    check("t4_d0_busy", 32'(busy),     32'd1);
    @(negedge clk);
    check("t4_d1_req",  32'(imem_req), 32'd0);
    check("t4_d1_busy", 32'(busy),     32'd1);
    @(negedge clk);
    check("t4_d2_req",  32'(imem_req), 32'd0);
    check("t4_d2_busy", 32'(busy),     32'd0);
    repeat (2) @(negedge clk);
    check("t4_drained_valid", 32'(instr_valid), 32'd0);
    check("t4_sb_empty",      32'(exp_q.size()), 32'd0);

    // 5: PC wrap after redirect to the top word
    step();
    run = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_req("t5_req_seen");
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t5_addr_wrap", imem_addr, 32'h0000_0000);

    // 6: asynchronous reset mid-stream
    repeat (3) @(negedge clk);
    check("t6_pre_valid", 32'(instr_valid), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("t6_req",   32'(imem_req),    32'd0);
    check("t6_addr",  imem_addr,        RESET_PC);
    check("t6_instr", instr,            32'd0);
    check("t6_pc",    instr_pc,         32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_busy",  32'(busy),        32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_req("t6_req_seen");
    check("t6_first_addr", imem_addr, RESET_PC);
    repeat (4) @(negedge clk);
    step();
    run = 1'b0;
    repeat (6) @(negedge clk);
    check("end_valid",    32'(instr_valid),  32'd0);
    check("end_busy",     32'(busy),         32'd0);
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
